dds_sweep_ctrl: RTL

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_pkg.sv | 16 +
 rtl/dds_sweep_ctrl_if.sv | 34 +++
 rtl/dds_sweep_ctrl_dwell_timer.sv | 31 +++
 rtl/dds_sweep_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: sweep FSM states, default bus widths and the constant control byte.
// Imported by the sweep controller, its interface and the serial loader.
package dds_pkg;

   localparam int FTW_W_DEF   = 32;
   localparam int DWELL_W_DEF = 24;

   localparam logic [7:0] DDS_CTRL_DEFAULT = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DWELL = 2'd2
   } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep configuration/command inputs plus the valid/ready tuning-word channel to the serial loader.
// master = sweep controller, slave = the side that configures it and consumes words.
interface dds_sweep_ctrl_if
   import dds_pkg::*;
#(
   parameter int FTW_W   = FTW_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) ();

   logic               start;
   logic               abort;
   logic [FTW_W-1:0]   ftw_start;
   logic [FTW_W-1:0]   ftw_step;
   logic [FTW_W-1:0]   ftw_stop;
   logic [DWELL_W-1:0] dwell;
   logic               continuous;
   logic               word_valid;
   logic [FTW_W-1:0]   word_ftw;
   logic [7:0]         word_ctrl;
   logic               word_ready;
   logic               busy;
   logic               done;

   modport master (
      input  start, abort, ftw_start, ftw_step, ftw_stop, dwell, continuous, word_ready,
      output word_valid, word_ftw, word_ctrl, busy, done
   );

   modport slave (
      output start, abort, ftw_start, ftw_step, ftw_stop, dwell, continuous, word_ready,
      input  word_valid, word_ftw, word_ctrl, busy, done
   );

endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell down-counter: load on a word transfer, count while enabled, expire pulse on the last counted cycle.
// A load value of N yields expire_o in the N-th enabled cycle after the load.
module dds_dwell_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep: offers start + k*step words with valid/ready, dwelling between transfers.
// First word appears two edges after start; a word is held stable until the loader accepts it.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int FTW_W   = FTW_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input logic              clk,
   input logic              reset,
   dds_sweep_ctrl_if.master bus
);

   state_e             state_q, state_d;
   logic               launch_q, launch_d;
   logic [FTW_W-1:0]   cur_q, cur_d;
   logic [FTW_W-1:0]   fstart_q, fstart_d;
   logic [FTW_W-1:0]   step_q, step_d;
   logic [FTW_W-1:0]   stop_q, stop_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               cont_q, cont_d;
   logic               abort_pend_q, abort_pend_d;
   logic               done_q, done_d;

   logic [FTW_W:0]     sum;
   logic               sweep_end, xfer, eval, tmr_load, tmr_expire;

   dds_dwell_timer #(.W(DWELL_W)) u_dwell (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (dwell_q),
      .en_i       (state_q == ST_DWELL),
      .expire_o   (tmr_expire)
   );

   // The extra bit catches wrap-around so a carry ends the sweep instead of restarting low.
   assign sum       = {1'b0, cur_q} + {1'b0, step_q};
   assign sweep_end = sum[FTW_W] || (sum > {1'b0, stop_q}) || (step_q == '0) || (cur_q == stop_q);
   assign xfer      = (state_q == ST_ISSUE) && bus.word_ready;

   always_comb begin
      state_d      = state_q;
      launch_d     = 1'b0;
      cur_d        = cur_q;
      fstart_d     = fstart_q;
      step_d       = step_q;
      stop_d       = stop_q;
      dwell_d      = dwell_q;
      cont_d       = cont_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      eval         = 1'b0;
      tmr_load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            abort_pend_d = 1'b0;
            if (launch_q) begin
               state_d = ST_ISSUE;
            end else if (bus.start) begin
               fstart_d = bus.ftw_start;
               step_d   = bus.ftw_step;
               stop_d   = bus.ftw_stop;
               dwell_d  = bus.dwell;
               cont_d   = bus.continuous;
               cur_d    = bus.ftw_start;
               launch_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (xfer) begin
               if (abort_pend_q || bus.abort) begin
                  state_d      = ST_IDLE;
                  abort_pend_d = 1'b0;
               end else if (dwell_q == '0) begin
                  eval = 1'b1;
               end else begin
                  state_d  = ST_DWELL;
                  tmr_load = 1'b1;
               end
            end else if (bus.abort) begin
               abort_pend_d = 1'b1;
            end
         end
         ST_DWELL: begin
            if (bus.abort)       state_d = ST_IDLE;
            else if (tmr_expire) eval    = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (eval) begin
         if (!sweep_end) begin
            cur_d   = sum[FTW_W-1:0];
            state_d = ST_ISSUE;
         end else if (cont_q) begin
            cur_d   = fstart_q;
            state_d = ST_ISSUE;
         end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         launch_q     <= 1'b0;
         cur_q        <= '0;
         fstart_q     <= '0;
         step_q       <= '0;
         stop_q       <= '0;
         dwell_q      <= '0;
         cont_q       <= 1'b0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         launch_q     <= launch_d;
         cur_q        <= cur_d;
         fstart_q     <= fstart_d;
         step_q       <= step_d;
         stop_q       <= stop_d;
         dwell_q      <= dwell_d;
         cont_q       <= cont_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
      end
   end

   assign bus.word_valid = (state_q == ST_ISSUE);
   assign bus.word_ftw   = (state_q == ST_ISSUE) ? cur_q : '0;
   assign bus.word_ctrl  = DDS_CTRL_DEFAULT;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = done_q;

endmodule
